// File: rtl/di_fifo_term.sv
// di_fifo_term: host-bus terminal that bridges single-word register
// transfers to a pair of streaming FIFOs.
//   - TX FIFO: host DATA writes push, fabric drains through tx_valid/tx_ready.
//   - RX FIFO: fabric fills through rx_valid/rx_ready, host DATA reads pop.
//   - STATUS register reports FIFO levels, full/empty and sticky errors.
//   - CTRL register: bit0 flushes both FIFOs, bit1 clears sticky errors.
// Ports:
//   ifclk, resetb          clock (rising edge), async active-low reset
//   di_term_addr           terminal address; this block answers to TERM_ADDR
//   di_reg_addr            0 DATA, 1 STATUS, 2 CTRL, others unmapped
//   di_len                 transfer length (unused, always one word)
//   di_read_mode/req/read  host read phase, request pulse, read strobe
//   di_write_mode/write    host write phase, write strobe
//   di_reg_datai           write data
//   di_read_rdy/write_rdy  terminal ready for read/write strobe
//   di_reg_datao           read data
//   di_transfer_status     0 ok, 1 FIFO error, 2 unmapped register
//   tx_valid/data/ready    host-to-fabric stream
//   rx_valid/data/ready    fabric-to-host stream
module di_fifo_term #(
    parameter logic [15:0] TERM_ADDR  = 16'h0010,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic [15:0] di_term_addr,
    input  logic [31:0] di_reg_addr,
    input  logic [31:0] di_len,
    input  logic        di_read_mode,
    input  logic        di_read_req,
    input  logic        di_read,
    input  logic        di_write_mode,
    input  logic        di_write,
    input  logic [31:0] di_reg_datai,
    output logic        di_read_rdy,
    output logic        di_write_rdy,
    output logic [31:0] di_reg_datao,
    output logic [15:0] di_transfer_status,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic sel, is_data, is_status, is_ctrl, unmapped;
    logic wr_acc, flush, sticky_clr;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ovf_set, unf_set;
    logic overflow, underflow;
    logic read_rdy_q, pop_done;
    logic [31:0] datao_q, read_word, status_word;

    logic [31:0]           tx_mem [DEPTH];
    logic [31:0]           rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CNT_W-1:0]      tx_count, rx_count;

    // Length is implied (one word) and the read phase flag carries no extra
    // information beyond the request/strobe pulses.
    logic unused_inputs;
    assign unused_inputs = ^{di_len, di_read_mode};

    assign sel       = (di_term_addr == TERM_ADDR);
    assign is_data   = (di_reg_addr == 32'd0);
    assign is_status = (di_reg_addr == 32'd1);
    assign is_ctrl   = (di_reg_addr == 32'd2);
    assign unmapped  = (di_reg_addr > 32'd2);

    assign tx_full  = (tx_count == CNT_FULL);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CNT_FULL);
    assign rx_empty = (rx_count == '0);

    assign wr_acc     = di_write && sel;
    assign flush      = wr_acc && is_ctrl && di_reg_datai[0];
    assign sticky_clr = wr_acc && is_ctrl && di_reg_datai[1];

    assign tx_push = wr_acc && is_data && !tx_full;
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_push = rx_valid && rx_ready;
    // pop_done limits a DATA read to a single pop even if the strobe lingers.
    assign rx_pop  = di_read && sel && is_data && !rx_empty && !pop_done;

    assign ovf_set = wr_acc && is_data && tx_full;
    assign unf_set = di_read && sel && is_data && rx_empty && !pop_done;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rd_ptr];
    assign rx_ready = !rx_full;

    assign di_write_rdy = sel && di_write_mode;
    assign di_read_rdy  = sel && read_rdy_q;
    assign di_reg_datao = sel ? datao_q : 32'd0;

    assign status_word = {tx_full, rx_empty, overflow, underflow, 3'b000,
                          9'(rx_count), 7'b0000000, 9'(tx_count)};

    // Register selected at read request time.
    always_comb begin
        read_word = 32'd0;
        if (is_data && !rx_empty) begin
            read_word = rx_mem[rx_rd_ptr];
        end else if (is_status) begin
            read_word = status_word;
        end
    end

    always_comb begin
        di_transfer_status = 16'd0;
        if (sel && (di_read || di_write)) begin
            if (unmapped) begin
                di_transfer_status = 16'd2;
            end else if (is_data && ((di_write && tx_full) || (di_read && rx_empty))) begin
                di_transfer_status = 16'd1;
            end
        end
    end

    // FIFO storage is not reset; only pointers and counts define contents.
    always_ff @(posedge ifclk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= di_reg_datai;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
    end

    // TX pointers/count; flush overrides any same-cycle push or pop.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_ONE;
            else if (tx_pop && !tx_push) tx_count <= tx_count - CNT_ONE;
        end
    end

    // RX pointers/count; flush overrides any same-cycle push or pop.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_ONE;
            else if (rx_pop && !rx_push) rx_count <= rx_count - CNT_ONE;
        end
    end

    // Sticky error bits: a set wins over a clear in the same cycle.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)         overflow <= 1'b1;
            else if (sticky_clr) overflow <= 1'b0;
            if (unf_set)         underflow <= 1'b1;
            else if (sticky_clr) underflow <= 1'b0;
        end
    end

    // Read handshake: data and ready appear the cycle after the request and
    // ready drops the cycle after the strobe. A new request re-arms the pop.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            read_rdy_q <= 1'b0;
            datao_q    <= 32'd0;
            pop_done   <= 1'b0;
        end else begin
            if (di_read) begin
                read_rdy_q <= 1'b0;
                pop_done   <= 1'b1;
            end
            if (di_read_req && sel) begin
                read_rdy_q <= 1'b1;
                datao_q    <= read_word;
                pop_done   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_di_fifo_term.sv
// tb_di_fifo_term: directed self-checking bench for di_fifo_term.
// Inputs change 1 time unit after a rising edge; outputs are checked a
// further unit later, well clear of the next edge.
module tb_di_fifo_term;

    localparam logic [15:0] TERM = 16'h0010;

    logic        ifclk;
    logic        resetb;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_read_mode, di_read_req, di_read;
    logic        di_write_mode, di_write;
    logic [31:0] di_reg_datai;
    logic        di_read_rdy, di_write_rdy;
    logic [31:0] di_reg_datao;
    logic [15:0] di_transfer_status;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    di_fifo_term dut (
        .ifclk              (ifclk),
        .resetb             (resetb),
        .di_term_addr       (di_term_addr),
        .di_reg_addr        (di_reg_addr),
        .di_len             (di_len),
        .di_read_mode       (di_read_mode),
        .di_read_req        (di_read_req),
        .di_read            (di_read),
        .di_write_mode      (di_write_mode),
        .di_write           (di_write),
        .di_reg_datai       (di_reg_datai),
        .di_read_rdy        (di_read_rdy),
        .di_write_rdy       (di_write_rdy),
        .di_reg_datao       (di_reg_datao),
        .di_transfer_status (di_transfer_status),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .rx_valid           (rx_valid),
        .rx_data            (rx_data),
        .rx_ready           (rx_ready)
    );

    initial begin
        ifclk = 1'b0;
        forever #5 ifclk = ~ifclk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge ifclk);
        #1;
    endtask

    // One host write transfer; transfer status is checked during the strobe.
    task automatic do_write(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [15:0] exp_status);
        di_term_addr  = TERM;
        di_reg_addr   = addr;
        di_reg_datai  = data;
        di_write_mode = 1'b1;
        di_write      = 1'b1;
        #1;
        check_output({tag, " write_rdy"}, 32'(di_write_rdy), 32'd1);
        check_output({tag, " wstatus"}, 32'(di_transfer_status), 32'(exp_status));
        next_cycle();
        di_write      = 1'b0;
        di_write_mode = 1'b0;
    endtask

    // One host read transfer: request, data check, strobe, ready release.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [15:0] exp_status);
        di_term_addr = TERM;
        di_reg_addr  = addr;
        di_read_mode = 1'b1;
        di_read_req  = 1'b1;
        next_cycle();
        di_read_req = 1'b0;
        check_output({tag, " read_rdy"}, 32'(di_read_rdy), 32'd1);
        check_output({tag, " rdata"}, di_reg_datao, exp_data);
        di_read = 1'b1;
        #1;
        check_output({tag, " rstatus"}, 32'(di_transfer_status), 32'(exp_status));
        next_cycle();
        di_read = 1'b0;
        check_output({tag, " rdy_clear"}, 32'(di_read_rdy), 32'd0);
        di_read_mode = 1'b0;
    endtask

    task automatic fabric_push(input string tag, input logic [31:0] word);
        check_output({tag, " rx_ready"}, 32'(rx_ready), 32'd1);
        rx_valid = 1'b1;
        rx_data  = word;
        next_cycle();
        rx_valid = 1'b0;
    endtask

    initial begin
        resetb        = 1'b0;
        di_term_addr  = TERM;
        di_reg_addr   = 32'd0;
        di_len        = 32'd1;
        di_read_mode  = 1'b0;
        di_read_req   = 1'b0;
        di_read       = 1'b0;
        di_write_mode = 1'b0;
        di_write      = 1'b0;
        di_reg_datai  = 32'd0;
        tx_ready      = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 32'd0;

        // Reset state
        repeat (2) next_cycle();
        check_output("rst tx_valid", 32'(tx_valid), 32'd0);
        check_output("rst rx_ready", 32'(rx_ready), 32'd1);
        check_output("rst read_rdy", 32'(di_read_rdy), 32'd0);
        check_output("rst datao", di_reg_datao, 32'd0);
        resetb = 1'b1;
        next_cycle();

        // Single DATA write shows up on the TX stream
        do_write("wr1", 32'd0, 32'hA5A5_0001, 16'd0);
        check_output("wr1 tx_valid", 32'(tx_valid), 32'd1);
        check_output("wr1 tx_data", tx_data, 32'hA5A5_0001);
        do_read("st1", 32'd1, 32'h4000_0001, 16'd0);

        // Push and pop on the same edge keep the count at 1
        tx_ready = 1'b1;
        do_write("wrpp", 32'd0, 32'h0000_0777, 16'd0);
        tx_ready = 1'b0;
        check_output("pp tx_data", tx_data, 32'h0000_0777);
        do_read("st_pp", 32'd1, 32'h4000_0001, 16'd0);
        tx_ready = 1'b1;
        next_cycle();
        tx_ready = 1'b0;
        check_output("drain1 tx_valid", 32'(tx_valid), 32'd0);

        // Fabric to host: two words return in order
        fabric_push("rxp1", 32'h1234_5678);
        fabric_push("rxp2", 32'h9ABC_DEF0);
        do_read("st_rx2", 32'd1, 32'h0002_0000, 16'd0);
        do_read("rd1", 32'd0, 32'h1234_5678, 16'd0);
        do_read("rd2", 32'd0, 32'h9ABC_DEF0, 16'd0);
        do_read("st_rx0", 32'd1, 32'h4000_0000, 16'd0);

        // Fill TX, then one more write is dropped with overflow
        for (int i = 0; i < 16; i++) begin
            do_write("fill", 32'd0, 32'hB000_0000 + 32'(i), 16'd0);
        end
        do_write("wr17", 32'd0, 32'hDEAD_0017, 16'd1);
        do_read("st_full", 32'd1, 32'hE000_0010, 16'd0);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_output("drain tx_data", tx_data, 32'hB000_0000 + 32'(i));
            next_cycle();
        end
        tx_ready = 1'b0;
        check_output("drain tx_valid", 32'(tx_valid), 32'd0);

        // Empty DATA read, then clear sticky bits via CTRL
        do_read("rd_empty", 32'd0, 32'd0, 16'd1);
        do_read("st_sticky", 32'd1, 32'h7000_0000, 16'd0);
        do_write("clr", 32'd2, 32'h0000_0002, 16'd0);
        do_read("st_clr", 32'd1, 32'h4000_0000, 16'd0);

        // Unmapped register
        do_read("rd_unmap", 32'd7, 32'd0, 16'd2);

        // Other terminal address: outputs stay 0 and FIFOs are untouched
        fabric_push("rxp3", 32'hCAFE_0001);
        di_term_addr  = 16'h0011;
        di_reg_addr   = 32'd0;
        di_reg_datai  = 32'h0000_0BAD;
        di_write_mode = 1'b1;
        di_write      = 1'b1;
        #1;
        check_output("nsel write_rdy", 32'(di_write_rdy), 32'd0);
        check_output("nsel wstatus", 32'(di_transfer_status), 32'd0);
        next_cycle();
        di_write      = 1'b0;
        di_write_mode = 1'b0;
        check_output("nsel tx_valid", 32'(tx_valid), 32'd0);
        di_read_mode = 1'b1;
        di_read_req  = 1'b1;
        next_cycle();
        di_read_req = 1'b0;
        check_output("nsel read_rdy", 32'(di_read_rdy), 32'd0);
        check_output("nsel datao", di_reg_datao, 32'd0);
        di_read = 1'b1;
        next_cycle();
        di_read      = 1'b0;
        di_read_mode = 1'b0;
        do_read("st_nsel", 32'd1, 32'h0001_0000, 16'd0);

        // Flush in the same cycle as a fabric push
        do_write("pf1", 32'd0, 32'h0000_0001, 16'd0);
        do_write("pf2", 32'd0, 32'h0000_0002, 16'd0);
        di_term_addr  = TERM;
        di_reg_addr   = 32'd2;
        di_reg_datai  = 32'h0000_0001;
        di_write_mode = 1'b1;
        di_write      = 1'b1;
        rx_valid      = 1'b1;
        rx_data       = 32'hDEAD_BEEF;
        next_cycle();
        di_write      = 1'b0;
        di_write_mode = 1'b0;
        rx_valid      = 1'b0;
        check_output("flush tx_valid", 32'(tx_valid), 32'd0);
        do_read("st_flush", 32'd1, 32'h4000_0000, 16'd0);

        // Reset during a pending read aborts it
        fabric_push("rxp4", 32'h0000_0011);
        di_reg_addr  = 32'd0;
        di_read_mode = 1'b1;
        di_read_req  = 1'b1;
        next_cycle();
        di_read_req = 1'b0;
        check_output("pre_rst read_rdy", 32'(di_read_rdy), 32'd1);
        resetb = 1'b0;
        #1;
        check_output("mid_rst read_rdy", 32'(di_read_rdy), 32'd0);
        check_output("mid_rst datao", di_reg_datao, 32'd0);
        check_output("mid_rst rx_ready", 32'(rx_ready), 32'd1);
        di_read_mode = 1'b0;
        next_cycle();
        resetb = 1'b1;
        next_cycle();
        do_read("st_rst", 32'd1, 32'h4000_0000, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/di_fifo_term.md
DI_FIFO_TERM -- requirements
Module: di_fifo_term

Interface
REQ-001 SHALL have parameter TERM_ADDR, default 16'h0010: terminal address this block answers to.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, legal range 1..8: each FIFO holds 2**DEPTH_LOG2 32-bit words.
REQ-003 SHALL have port ifclk  input  1  clock; all logic is on its rising edge.
REQ-004 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port di_term_addr  input  16  terminal address of the current transfer.
REQ-006 SHALL have port di_reg_addr  input  32  register address: 0 DATA, 1 STATUS, 2 CTRL; any other value is unmapped.
REQ-007 SHALL have port di_len  input  32  transfer length; ignored, because every transfer is one word.
REQ-008 SHALL have ports di_read_mode, di_read_req, di_read  input  1 each  host read phase, read request pulse, read strobe.
REQ-009 SHALL have ports di_write_mode, di_write  input  1 each  host write phase, write strobe.
REQ-010 SHALL have port di_reg_datai  input  32  write data.
REQ-011 SHALL have ports di_read_rdy, di_write_rdy  output  1 each  terminal ready for the read or write strobe.
REQ-012 SHALL have port di_reg_datao  output  32  read data.
REQ-013 SHALL have port di_transfer_status  output  16  0 = ok, 1 = FIFO error, 2 = unmapped register.
REQ-014 SHALL have ports tx_valid  output  1, tx_data  output  32, tx_ready  input  1  forming the host-to-fabric stream.
REQ-015 SHALL have ports rx_valid  input  1, rx_data  input  32, rx_ready  output  1  forming the fabric-to-host stream.

Function
REQ-016 sel SHALL be (di_term_addr == TERM_ADDR); while sel=0, di_read_rdy, di_write_rdy, di_reg_datao and di_transfer_status SHALL all be 0, so several terminals can be OR-combined.
REQ-017 TX FIFO: a DATA write pushes it; the fabric pops it on tx_valid&&tx_ready; tx_valid = !tx_empty; tx_data = head word, combinational.
REQ-018 RX FIFO: the fabric pushes it on rx_valid&&rx_ready; rx_ready = !rx_full; a DATA read pops it.
REQ-019 Each FIFO SHALL use wrapping pointers plus a count; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-020 di_write_rdy SHALL equal sel && di_write_mode, combinationally.
REQ-021 A write is accepted when di_write && sel.
  - DATA, TX not full: push di_reg_datai.
  - DATA, TX full: drop the word, set sticky overflow.
  - CTRL bit0=1: flush both FIFOs (pointers and counts to 0).
  - CTRL bit1=1: clear the overflow and underflow sticky bits.
REQ-022 Read handshake: when di_read_req && sel, di_reg_datao SHALL be registered from the addressed register and di_read_rdy SHALL be set the next cycle; di_read_rdy SHALL clear in the cycle after di_read.
REQ-023 Read data by register:
  - DATA, RX not empty: RX head word.
  - DATA, RX empty: 0, and sticky underflow set at di_read.
  - STATUS: {tx_full, rx_empty, overflow, underflow, 3'b0, rx_count[8:0], 7'b0, tx_count[8:0]}.
  - CTRL and unmapped: 0.
REQ-024 A DATA read SHALL pop RX on the di_read cycle when not empty; exactly one pop per transfer.
REQ-025 di_transfer_status SHALL be combinational and valid during di_read/di_write.
  - 1: DATA write while TX full, or DATA read while RX empty.
  - 2: unmapped register.
  - 0: otherwise.
REQ-026 Simultaneous events:
  - Flush SHALL take priority over a fabric push or pop in the same cycle.
  - A sticky set SHALL take priority over a sticky clear in the same cycle.
REQ-027 Read latency: di_read_req at cycle T gives data and di_read_rdy at T+1.

Reset
REQ-028 While resetb=0, SHALL hold: both FIFOs empty, pointers 0, sticky bits 0, di_read_rdy=0, di_reg_datao=0, tx_valid=0, rx_ready=1.
REQ-029 Reset mid-transfer SHALL abort the transfer with no push or pop; FIFO memory contents need not be cleared.

Verification
REQ-030 DATA write 32'hA5A5_0001 with tx_ready=0 -> tx_valid=1, tx_data=32'hA5A5_0001, STATUS[8:0]=1, status 0.
REQ-031 Fabric pushes 32'h1234_5678 and 32'h9ABC_DEF0; host reads DATA twice -> the words return in order; STATUS bit30=1 afterwards.
REQ-032 Fill TX with 16 writes (DEPTH_LOG2=4), then a 17th write -> 17th transfer status 1, word dropped, STATUS bit31=1 and bit29=1, tx_count=16.
REQ-033 DATA read with RX empty -> di_reg_datao=0, status 1, underflow set; CTRL write 32'h2 -> sticky bits 0.
REQ-034 Read of reg_addr 7 -> data 0, status 2; any transfer with di_term_addr != TERM_ADDR -> all di outputs stay 0.
REQ-035 CTRL write 32'h1 in the same cycle as rx_valid=1, with both FIFOs partly full -> both counts 0 next cycle, the pushed word lost.
